// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer: opcodes, ALU function codes,
// the packed ALU control word and the sequencer state encoding.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_NEG_X = 3'd4;
  localparam logic [2:0] OP_INC_X = 3'd5;
  localparam logic [2:0] OP_DEC_X = 3'd6;
  localparam logic [2:0] OP_MUL   = 3'd7;

  localparam logic [1:0] F_AND = 2'b00;
  localparam logic [1:0] F_ADD = 2'b01;

  // Field order matches the Hack control word: zx nx zy ny f no
  typedef struct packed {
    logic       zx;
    logic       nx;
    logic       zy;
    logic       ny;
    logic [1:0] f;
    logic       no;
  } ctrl_t;

  localparam ctrl_t CTRL_ADD = '{zx: 1'b0, nx: 1'b0, zy: 1'b0, ny: 1'b0,
                                 f: F_ADD, no: 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Command / response handshake bundle of the ALU sequencer.
//   cmd_valid/cmd_ready, cmd_op[2:0], cmd_a, cmd_b : command channel
//   rsp_valid/rsp_ready, rsp_data, rsp_zr, rsp_ng  : response channel
// master : the command issuer / response consumer
// slave  : the sequencer
// -----------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zr;
  logic             rsp_ng;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zr, rsp_ng
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zr, rsp_ng
  );

endinterface

// File: rtl/alu_sequencer_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
// Combinational opcode to Hack ALU control word decode.
//   i_op   : opcode
//   o_ctrl : {zx, nx, zy, ny, f, no}
// MUL has no single-cycle encoding; it decodes to ADD, the operation its
// iterations use.
// -----------------------------------------------------------------------------
module alu_op_decoder
  import alu_seq_pkg::*;
(
  input  logic [2:0] i_op,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_ADD;
    case (i_op)
      OP_ADD:   o_ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, F_ADD, 1'b0};
      OP_SUB:   o_ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, F_ADD, 1'b1};
      OP_AND:   o_ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, F_AND, 1'b0};
      OP_OR:    o_ctrl = '{1'b0, 1'b1, 1'b0, 1'b1, F_AND, 1'b1};
      OP_NEG_X: o_ctrl = '{1'b0, 1'b0, 1'b1, 1'b1, F_ADD, 1'b1};
      OP_INC_X: o_ctrl = '{1'b0, 1'b1, 1'b1, 1'b1, F_ADD, 1'b1};
      OP_DEC_X: o_ctrl = '{1'b0, 1'b0, 1'b1, 1'b1, F_ADD, 1'b0};
      default:  o_ctrl = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Command-driven controller for an external 16-bit Hack-style ALU. Accepts
// one operation at a time, drives ALU operands/controls, runs MUL as
// iterative shift-and-add through the ALU adder and returns result + flags.
//
// Ports
//   i_clk, i_rst           : clock, synchronous active-high reset
//   bus (alu_seq_if.slave) : command / response handshake
//   o_busy                 : state != IDLE
//   o_alu_a, o_alu_b       : ALU operands
//   o_alu_zx/nx/zy/ny/no   : ALU control bits, o_alu_f : ALU function
//   i_alu_out, i_alu_zr, i_alu_ng : ALU result and flags
//
// Build option
//   MUL_EARLY_EXIT_EN : MUL finishes as soon as the remaining multiplier is 0
//
// State | meaning
// IDLE  | ready for a command, ALU outputs parked at 0
// EXEC  | single-cycle op on the ALU, result captured
// MUL   | one shift-and-add iteration per cycle
// DONE  | response valid, held until rsp_ready
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  alu_seq_if.slave         bus,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_alu_zx,
  output logic             o_alu_nx,
  output logic             o_alu_zy,
  output logic             o_alu_ny,
  output logic [1:0]       o_alu_f,
  output logic             o_alu_no,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic             i_alu_zr,
  input  logic             i_alu_ng
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;      // operand x; multiplicand during MUL
  logic [WIDTH-1:0] r_b;      // operand y; multiplier during MUL
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zr;
  logic             r_rsp_ng;

  ctrl_t            w_dec_ctrl;
  ctrl_t            w_ctrl;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_mplier_next;
  logic             w_mul_last;

  alu_op_decoder u_dec (
    .i_op   (r_op),
    .o_ctrl (w_dec_ctrl)
  );

  assign w_acc_next    = r_b[0] ? i_alu_out : r_acc;
  assign w_mplier_next = r_b >> 1;

`ifdef MUL_EARLY_EXIT_EN
  assign w_mul_last = (r_cnt == LAST_CNT) || (w_mplier_next == '0);
`else
  assign w_mul_last = (r_cnt == LAST_CNT);
`endif

  always_comb begin
    w_state_next = r_state;
    w_ctrl       = ctrl_t'('0);
    o_alu_a      = '0;
    o_alu_b      = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid)
          w_state_next = (bus.cmd_op == OP_MUL) ? ST_MUL : ST_EXEC;
      end
      ST_EXEC: begin
        o_alu_a      = r_a;
        o_alu_b      = r_b;
        w_ctrl       = w_dec_ctrl;
        w_state_next = ST_DONE;
      end
      ST_MUL: begin
        o_alu_a = r_acc;
        o_alu_b = r_a;
        w_ctrl  = CTRL_ADD;
        if (w_mul_last)
          w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rsp_ready)
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_zr   <= 1'b0;
      r_rsp_ng   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_op  <= bus.cmd_op;
            r_a   <= bus.cmd_a;
            r_b   <= bus.cmd_b;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        ST_EXEC: begin
          r_rsp_data <= i_alu_out;
          r_rsp_zr   <= i_alu_zr;
          r_rsp_ng   <= i_alu_ng;
        end
        ST_MUL: begin
          r_acc <= w_acc_next;
          r_a   <= r_a << 1;
          r_b   <= w_mplier_next;
          r_cnt <= r_cnt + 1'b1;
          // flags come from the final product, not from the last ALU pass
          if (w_mul_last) begin
            r_rsp_data <= w_acc_next;
            r_rsp_zr   <= (w_acc_next == '0);
            r_rsp_ng   <= w_acc_next[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_alu_zx = w_ctrl.zx;
  assign o_alu_nx = w_ctrl.nx;
  assign o_alu_zy = w_ctrl.zy;
  assign o_alu_ny = w_ctrl.ny;
  assign o_alu_f  = w_ctrl.f;
  assign o_alu_no = w_ctrl.no;

  assign o_busy        = (r_state != ST_IDLE);
  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_zr    = r_rsp_zr;
  assign bus.rsp_ng    = r_rsp_ng;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer with a behavioural Hack ALU attached.
// Expected results come from plain arithmetic on the operands and are queued
// when a command is accepted, then popped when the response appears.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             zr;
    logic             ng;
    int               lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  logic             busy;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic             alu_zx, alu_nx, alu_zy, alu_ny, alu_no, alu_zr, alu_ng;
  logic [1:0]       alu_f;

  alu_sequencer #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .o_busy    (busy),
    .o_alu_a   (alu_a),
    .o_alu_b   (alu_b),
    .o_alu_zx  (alu_zx),
    .o_alu_nx  (alu_nx),
    .o_alu_zy  (alu_zy),
    .o_alu_ny  (alu_ny),
    .o_alu_f   (alu_f),
    .o_alu_no  (alu_no),
    .i_alu_out (alu_out),
    .i_alu_zr  (alu_zr),
    .i_alu_ng  (alu_ng)
  );

  // Behavioural Hack ALU
  logic [WIDTH-1:0] m_x, m_y, m_r;
  always_comb begin
    m_x = alu_zx ? '0 : alu_a;
    if (alu_nx) m_x = ~m_x;
    m_y = alu_zy ? '0 : alu_b;
    if (alu_ny) m_y = ~m_y;
    m_r = (alu_f == F_ADD) ? (m_x + m_y) : (m_x & m_y);
    if (alu_no) m_r = ~m_r;
  end
  assign alu_out = m_r;
  assign alu_zr  = (m_r == '0);
  assign alu_ng  = m_r[WIDTH-1];

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Edge, counted from the accept edge, at which rsp_valid is first sampled high
  function automatic int mul_lat(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int c = 1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) c = i + 1;
    return 1 + c;
`else
    return 1 + WIDTH;
`endif
  endfunction

  function automatic exp_t ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a, b);
    exp_t e;
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_NEG_X: r = -a;
      OP_INC_X: r = a + 16'd1;
      OP_DEC_X: r = a - 16'd1;
      default:  r = a * b;
    endcase
    e.data = r;
    e.zr   = (r == '0);
    e.ng   = r[WIDTH-1];
    e.lat  = (op == OP_MUL) ? mul_lat(b) : 2;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command until accepted; returns just after the accept edge.
  task automatic drive_cmd(input logic [2:0] op, input logic [WIDTH-1:0] a, b,
                           output logic accepted);
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    accepted      = 1'b0;
    for (int i = 0; i < TIMEOUT && !accepted; i++) begin
      accepted = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
  endtask

  // Called just after the accept edge; lat is the edge index of first valid.
  task automatic wait_rsp(output logic seen, output int lat);
    seen = 1'b0;
    lat  = 1;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    tick(); tick();
    n_cmp++;
    if ({busy, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL reset_status: busy/rsp_valid/cmd_ready=%b want 001",
               {busy, bus.rsp_valid, bus.cmd_ready});
    end
    n_cmp++;
    if ({bus.rsp_data, bus.rsp_zr, bus.rsp_ng} !== '0) begin
      n_err++;
      $display("FAIL reset_rsp: data=%h zr=%b ng=%b want 0", bus.rsp_data, bus.rsp_zr, bus.rsp_ng);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== '0) begin
      n_err++;
      $display("FAIL reset_alu: a=%h b=%h ctrl=%b want 0", alu_a, alu_b,
               {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_ops();
    logic [2:0]       t_op [9] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG_X,
                                   OP_INC_X, OP_DEC_X, OP_ADD, OP_SUB};
    logic [WIDTH-1:0] t_a  [9] = '{16'h0001, 16'h0003, 16'h00F0, 16'h00F0, 16'h0001,
                                   16'hFFFF, 16'h0000, 16'hFFFF, 16'h8000};
    logic [WIDTH-1:0] t_b  [9] = '{16'h0001, 16'h0005, 16'h0F00, 16'h0F00, 16'h1234,
                                   16'h5555, 16'hAAAA, 16'h0002, 16'h0001};
    logic [6:0]       t_cw [9] = '{7'b0000010, 7'b0100011, 7'b0000000, 7'b0101001,
                                   7'b0011011, 7'b0111011, 7'b0011010, 7'b0000010,
                                   7'b0100011};
    logic acc, seen;
    int   lat;
    exp_t e;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_cmd(t_op[i], t_a[i], t_b[i], acc);
      n_cmp++;
      if (acc !== 1'b1) begin
        n_err++;
        $display("FAIL op%0d_accept: got %b want 1", i, acc);
      end
      sb.push_back(ref_op(t_op[i], t_a[i], t_b[i]));
      n_cmp++;
      if ({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_a, alu_b}
          !== {t_cw[i], t_a[i], t_b[i]}) begin
        n_err++;
        $display("FAIL op%0d_alu_drive: ctrl=%b a=%h b=%h want ctrl=%b a=%h b=%h", i,
                 {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, alu_a, alu_b,
                 t_cw[i], t_a[i], t_b[i]);
      end
      wait_rsp(seen, lat);
      e = sb.pop_front();
      n_cmp++;
      if ({seen, bus.rsp_data, bus.rsp_zr, bus.rsp_ng} !== {1'b1, e.data, e.zr, e.ng}) begin
        n_err++;
        $display("FAIL op%0d_result: valid=%b data=%h zr=%b ng=%b want 1 %h %b %b", i,
                 seen, bus.rsp_data, bus.rsp_zr, bus.rsp_ng, e.data, e.zr, e.ng);
      end
      n_cmp++;
      if (lat !== e.lat) begin
        n_err++;
        $display("FAIL op%0d_latency: got %0d want %0d", i, lat, e.lat);
      end
      tick();
    end
  endtask

  task automatic test_mul();
    logic [WIDTH-1:0] t_a [6] = '{16'h0007, 16'h0100, 16'h1234, 16'hFFFF, 16'h1234, 16'h8001};
    logic [WIDTH-1:0] t_b [6] = '{16'h0006, 16'h0100, 16'h0001, 16'hFFFF, 16'h0000, 16'h8003};
    logic acc, seen;
    int   lat;
    exp_t e;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cmd(OP_MUL, t_a[i], t_b[i], acc);
      sb.push_back(ref_op(OP_MUL, t_a[i], t_b[i]));
      n_cmp++;
      if ({acc, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_a, alu_b}
          !== {1'b1, 7'b0000010, 16'h0000, t_a[i]}) begin
        n_err++;
        $display("FAIL mul%0d_first_iter: acc=%b ctrl=%b a=%h b=%h want 1 0000010 0000 %h", i,
                 acc, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, alu_a, alu_b, t_a[i]);
      end
      wait_rsp(seen, lat);
      e = sb.pop_front();
      n_cmp++;
      if ({seen, bus.rsp_data, bus.rsp_zr, bus.rsp_ng} !== {1'b1, e.data, e.zr, e.ng}) begin
        n_err++;
        $display("FAIL mul%0d_result: valid=%b data=%h zr=%b ng=%b want 1 %h %b %b", i,
                 seen, bus.rsp_data, bus.rsp_zr, bus.rsp_ng, e.data, e.zr, e.ng);
      end
      n_cmp++;
      if (lat !== e.lat) begin
        n_err++;
        $display("FAIL mul%0d_latency: got %0d want %0d", i, lat, e.lat);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_mul();
    logic acc;
    logic leaked = 1'b0;
    bus.rsp_ready = 1'b1;
    drive_cmd(OP_MUL, 16'h0007, 16'hFFFF, acc);
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if ({acc, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL midmul_busy: accepted=%b busy=%b want 11", acc, busy);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({busy, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL midmul_reset_status: busy/rsp_valid/cmd_ready=%b want 001",
               {busy, bus.rsp_valid, bus.cmd_ready});
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== '0) begin
      n_err++;
      $display("FAIL midmul_reset_alu: a=%h b=%h ctrl=%b want 0", alu_a, alu_b,
               {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) leaked = 1'b1;
      tick();
    end
    n_cmp++;
    if (leaked !== 1'b0) begin
      n_err++;
      $display("FAIL midmul_no_response: rsp_valid seen=%b want 0", leaked);
    end
  endtask

  task automatic test_backpressure();
    logic acc, seen;
    int   lat;
    exp_t e;
    logic hold_ok = 1'b1;
    bus.rsp_ready = 1'b0;
    drive_cmd(OP_INC_X, 16'h7FFF, 16'h0000, acc);
    sb.push_back(ref_op(OP_INC_X, 16'h7FFF, 16'h0000));
    wait_rsp(seen, lat);
    e = sb.pop_front();
    bus.cmd_op = OP_ADD; bus.cmd_a = 16'h0001; bus.cmd_b = 16'h0001;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_ng}
          !== {1'b1, 1'b0, e.data, e.ng}) begin
        hold_ok = 1'b0;
        $display("cycle %0d: valid=%b ready=%b data=%h ng=%b", i, bus.rsp_valid,
                 bus.cmd_ready, bus.rsp_data, bus.rsp_ng);
      end
      tick();
    end
    n_cmp++;
    if ({acc, seen, hold_ok} !== 3'b111) begin
      n_err++;
      $display("FAIL backpressure_hold: accepted=%b seen=%b held=%b want 111 (data %h ng %b)",
               acc, seen, hold_ok, e.data, e.ng);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if ({busy, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL backpressure_release: busy/rsp_valid/cmd_ready=%b want 001",
               {busy, bus.rsp_valid, bus.cmd_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic acc, seen;
    int   lat;
    exp_t e;
    logic [2:0] op;
    logic [WIDTH-1:0] a, b;
    int   accept_at[$];
    logic overlap = 1'b0;
    int   bad = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      drive_cmd(op, a, b, acc);
      sb.push_back(ref_op(op, a, b));
      wait_rsp(seen, lat);
      e = sb.pop_front();
      if ({acc, seen, bus.rsp_data, bus.rsp_zr, bus.rsp_ng, lat}
          !== {1'b1, 1'b1, e.data, e.zr, e.ng, e.lat}) begin
        bad++;
        $display("rand %0d op=%0d a=%h b=%h: data=%h zr=%b ng=%b lat=%0d exp %h %b %b %0d",
                 i, op, a, b, bus.rsp_data, bus.rsp_zr, bus.rsp_ng, lat,
                 e.data, e.zr, e.ng, e.lat);
      end
      tick();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL random_ops: %0d bad responses want 0", bad);
    end
    // continuous command stream: accepts land every 3rd edge
    bus.cmd_op = OP_ADD; bus.cmd_a = 16'h0002; bus.cmd_b = 16'h0003;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (bus.cmd_ready) accept_at.push_back(i);
      if (bus.cmd_ready && bus.rsp_valid) overlap = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    n_cmp++;
    if (accept_at.size() != 3 || overlap) begin
      n_err++;
      $display("FAIL issue_interval: accepts=%0d overlap=%b want 3 0", accept_at.size(), overlap);
    end else begin
      n_cmp++;
      if ({accept_at[0], accept_at[1], accept_at[2]} !== {32'd0, 32'd3, 32'd6}) begin
        n_err++;
        $display("FAIL issue_spacing: edges %0d %0d %0d want 0 3 6",
                 accept_at[0], accept_at[1], accept_at[2]);
      end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    test_reset();
    test_single_ops();
    test_mul();
    test_reset_mid_mul();
    test_backpressure();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven controller that owns the 16-bit Hack-style ALU.
- Accepts one operation at a time over a valid/ready command port.
- Decodes the opcode into ALU control bits (zx, nx, zy, ny, f, no) and drives the ALU operands.
- Runs multi-cycle multiply as iterative shift-and-add through the ALU's adder, then returns result and flags over a valid/ready response port.

Parameters:
- WIDTH, 16, datapath width; must match ALU width.
- CNT_W, 4, multiply iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  3  opcode
- cmd_a  input  WIDTH  operand x
- cmd_b  input  WIDTH  operand y
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_data  output  WIDTH  result
- rsp_zr  output  1  result == 0
- rsp_ng  output  1  result MSB
- busy  output  1  state != IDLE
- alu_a, alu_b  output  WIDTH  ALU operands
- alu_zx, alu_nx, alu_zy, alu_ny, alu_no  output  1  ALU control
- alu_f  output  2  ALU function: 00 = x&y, 01 = x+y
- alu_out  input  WIDTH  ALU result
- alu_zr, alu_ng  input  1  ALU flags

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous, active-high.
- Reset: state IDLE; all response and ALU outputs 0; internal registers 0. Assertion mid-operation aborts immediately with no response.
- Opcodes, as control word zx nx zy ny f no:
  - 0 ADD: 0 0 0 0 01 0
  - 1 SUB (x-y): 0 1 0 0 01 1
  - 2 AND: 0 0 0 0 00 0
  - 3 OR: 0 1 0 1 00 1
  - 4 NEG_X: 0 0 1 1 01 1
  - 5 INC_X: 0 1 1 1 01 1
  - 6 DEC_X: 0 0 1 1 01 0
  - 7 MUL: multi-cycle
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch op, a and b.
  - Go to MUL if op == 7, else EXEC.
  - ALU outputs are driven to 0 in IDLE and DONE.
- EXEC (1 cycle):
  - alu_a/alu_b = latched operands; control from the decode table.
  - Capture alu_out, alu_zr, alu_ng into the response registers; go to DONE.
- MUL:
  - Registers: acc = 0, mcand = a, mplier = b, cnt = 0.
  - Each cycle: alu_a = acc, alu_b = mcand, control = ADD.
  - If mplier[0], acc <= alu_out.
  - Every cycle: mcand <<= 1, mplier >>= 1, cnt++.
  - After the cnt == WIDTH-1 cycle, the response takes acc's final value; go to DONE.
  - Result is the low WIDTH bits of the product (modulo 2^WIDTH, signed/unsigned identical).
  - zr/ng are computed from the final value, not from ALU flags.
- DONE:
  - rsp_valid = 1; rsp_data/zr/ng held stable.
  - On rsp_ready, go to IDLE.
- Latency (command accepted at edge N):
  - Single-cycle ops: rsp_valid from edge N+2.
  - MUL: rsp_valid from edge N+1+WIDTH, i.e. N+17.
- Back-to-back:
  - cmd_ready is low outside IDLE; a command is never accepted in the same cycle a response is consumed.
  - Minimum issue interval is 3 cycles.
- rsp_ready while not DONE is ignored. cmd_valid while busy is ignored (no latch).
- Overflow: ADD, SUB, INC and DEC wrap modulo 2^16; no overflow flag.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: MUL exits to DONE at the end of the first MUL cycle in which the shifted mplier becomes 0, or after WIDTH cycles, whichever is first. b = 0 therefore takes 1 MUL cycle, and latency varies.
- Undefined: MUL always takes exactly WIDTH cycles.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD..OP_MUL;
  - F_AND/F_ADD codes;
  - packed control-word typedef {zx,nx,zy,ny,f,no};
  - state enum.
- Sub-module alu_op_decoder: combinational opcode -> control word.

Test Plan:
- Reset mid-MUL (rst after 5 MUL cycles): next cycle busy = 0, rsp_valid = 0, all ALU outputs 0, cmd_ready = 1.
- ADD a = 0x0001, b = 0x0001, rsp_ready = 1: alu control 0 0 0 0 01 0, rsp_data = 0x0002, zr = 0, ng = 0, rsp_valid exactly 2 cycles after accept.
- SUB a = 0x0003, b = 0x0005: rsp_data = 0xFFFE, ng = 1. Then AND a = 0x00F0, b = 0x0F00: rsp_data = 0x0000, zr = 1.
- MUL a = 0x0007, b = 0x0006: rsp_data = 0x002A, rsp_valid at accept + 17 (without MUL_EARLY_EXIT_EN). MUL a = 0x0100, b = 0x0100: rsp_data = 0x0000, zr = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles after INC_X a = 0x7FFF. rsp_data stays 0x8000, ng = 1; cmd_ready stays 0; a new cmd_valid is not accepted.
- With MUL_EARLY_EXIT_EN: MUL a = 0x1234, b = 0x0001 completes at accept + 2 with rsp_data = 0x1234.
